// File: rtl/gpr_access_ctrl_if.sv
// Request/response and register-file bus bundle for gpr_access_ctrl.
//   master : the controller (drives fetch_ready, op_*, wb_ready, gpr_cs/read/address, bus_err)
//   slave  : execute stage + register file (drives fetch_*, wb_*, gpr_rdy)
// The shared gpr_data bus is a tri-state net and is carried as a plain inout port instead.
interface gpr_access_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned REG_SEL    = 3
);
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [REG_SEL-1:0]    fetch_rs1;
  logic [REG_SEL-1:0]    fetch_rs2;
  logic                  op_valid;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_SEL-1:0]    wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  gpr_cs;
  logic                  gpr_read;
  logic [ADDR_WIDTH-1:0] gpr_address;
  logic                  gpr_rdy;
  logic                  bus_err;

  modport master (
    input  fetch_valid, fetch_rs1, fetch_rs2, wb_valid, wb_rd, wb_data, gpr_rdy,
    output fetch_ready, op_valid, op_a, op_b, wb_ready, gpr_cs, gpr_read, gpr_address, bus_err
  );

  modport slave (
    output fetch_valid, fetch_rs1, fetch_rs2, wb_valid, wb_rd, wb_data, gpr_rdy,
    input  fetch_ready, op_valid, op_a, op_b, wb_ready, gpr_cs, gpr_read, gpr_address, bus_err
  );
endinterface

// File: rtl/gpr_access_ctrl.sv
// Bus master in front of the general-purpose register file. Turns an operand fetch into two
// sequential reads (rs1, rs2) and a writeback into one write, with writeback priority, the
// register file's cs/rdy handshake, read-data capture and a sticky timeout flag.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   bus      - gpr_access_ctrl_if.master: fetch/op/wb handshakes, gpr_cs/read/address/rdy, bus_err
//   gpr_data - shared register-file data bus, driven only during a writeback's ISSUE/XFER
module gpr_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned REG_SEL    = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gpr_access_ctrl_if.master     bus,
  inout  wire [DATA_WIDTH-1:0]  gpr_data
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StXfer, StRelease} state_e;
  typedef enum logic [1:0] {JobWb, JobRd1, JobRd2} job_e;

  state_e                r_state, w_state_d;
  job_e                  r_job, w_job_d;
  logic [REG_SEL-1:0]    r_sel, w_sel_d;     // register currently on the address bus
  logic [REG_SEL-1:0]    r_rs2, w_rs2_d;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic                  r_cs, w_cs_d;
  logic                  r_read, w_read_d;
  logic                  r_drive, w_drive_d;
  logic                  r_op_valid, w_op_valid_d;
  logic [DATA_WIDTH-1:0] r_op_a, w_op_a_d;
  logic [DATA_WIDTH-1:0] r_op_b, w_op_b_d;
  logic                  r_bus_err, w_bus_err_d;
  logic                  w_fetch_ready, w_wb_ready, w_abort;

  always_comb begin
    w_state_d     = r_state;
    w_job_d       = r_job;
    w_sel_d       = r_sel;
    w_rs2_d       = r_rs2;
    w_wdata_d     = r_wdata;
    w_cnt_d       = r_cnt;
    w_cs_d        = r_cs;
    w_read_d      = r_read;
    w_drive_d     = r_drive;
    w_op_valid_d  = 1'b0;
    w_op_a_d      = r_op_a;
    w_op_b_d      = r_op_b;
    w_bus_err_d   = r_bus_err;
    w_fetch_ready = 1'b0;
    w_wb_ready    = 1'b0;
    w_abort       = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Only start when the register file reports idle; writeback wins a tie.
        if (bus.gpr_rdy) begin
          if (bus.wb_valid) begin
            w_wb_ready = 1'b1;
            w_job_d    = JobWb;
            w_sel_d    = bus.wb_rd;
            w_wdata_d  = bus.wb_data;
            w_state_d  = StIssue;
            w_cs_d     = 1'b1;
            w_read_d   = 1'b0;
            w_drive_d  = 1'b1;
            w_cnt_d    = '0;
          end else if (bus.fetch_valid) begin
            w_fetch_ready = 1'b1;
            w_job_d       = JobRd1;
            w_sel_d       = bus.fetch_rs1;
            w_rs2_d       = bus.fetch_rs2;
            w_state_d     = StIssue;
            w_cs_d        = 1'b1;
            w_read_d      = 1'b1;
            w_drive_d     = 1'b0;
            w_cnt_d       = '0;
          end
        end
      end

      StIssue: begin
        if (!bus.gpr_rdy) begin
          w_state_d = StXfer;
          w_cnt_d   = '0;
        end else if (r_cnt == CntW'(TIMEOUT)) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end

      StXfer: begin
        if (r_job == JobRd1) w_op_a_d = gpr_data;
        if (r_job == JobRd2) w_op_b_d = gpr_data;
        w_state_d = StRelease;
        w_cs_d    = 1'b0;
        w_read_d  = 1'b1;
        w_drive_d = 1'b0;
        w_cnt_d   = '0;
      end

      StRelease: begin
        if (bus.gpr_rdy) begin
          w_cnt_d = '0;
          if (r_job == JobRd1) begin
            w_job_d   = JobRd2;
            w_sel_d   = r_rs2;
            w_state_d = StIssue;
            w_cs_d    = 1'b1;
            w_read_d  = 1'b1;
          end else begin
            w_op_valid_d = (r_job == JobRd2);
            w_state_d    = StIdle;
          end
        end else if (r_cnt == CntW'(TIMEOUT)) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end

      default: w_state_d = StIdle;
    endcase

    // Timeout: drop the bus and abandon the job without any op_valid pulse.
    if (w_abort) begin
      w_bus_err_d = 1'b1;
      w_state_d   = StIdle;
      w_cs_d      = 1'b0;
      w_read_d    = 1'b1;
      w_drive_d   = 1'b0;
      w_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_job      <= JobWb;
      r_sel      <= '0;
      r_rs2      <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_cs       <= 1'b0;
      r_read     <= 1'b1;
      r_drive    <= 1'b0;
      r_op_valid <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_job      <= w_job_d;
      r_sel      <= w_sel_d;
      r_rs2      <= w_rs2_d;
      r_wdata    <= w_wdata_d;
      r_cnt      <= w_cnt_d;
      r_cs       <= w_cs_d;
      r_read     <= w_read_d;
      r_drive    <= w_drive_d;
      r_op_valid <= w_op_valid_d;
      r_op_a     <= w_op_a_d;
      r_op_b     <= w_op_b_d;
      r_bus_err  <= w_bus_err_d;
    end
  end

  assign bus.fetch_ready = w_fetch_ready;
  assign bus.wb_ready    = w_wb_ready;
  assign bus.op_valid    = r_op_valid;
  assign bus.op_a        = r_op_a;
  assign bus.op_b        = r_op_b;
  assign bus.gpr_cs      = r_cs;
  assign bus.gpr_read    = r_read;
  assign bus.gpr_address = ADDR_WIDTH'(r_sel);
  assign bus.bus_err     = r_bus_err;
  assign gpr_data        = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_gpr_access_ctrl.sv
// Self-checking bench for gpr_access_ctrl: behavioural register file on the bus, expected
// register contents kept as a plain array updated on every writeback.
module tb_gpr_access_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned RS = 3;
  localparam int unsigned TO = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpr_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_SEL(RS)) u_if ();
  wire [DW-1:0] gpr_data;

  gpr_access_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .REG_SEL   (RS),
    .TIMEOUT   (TO)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (u_if),
    .gpr_data(gpr_data)
  );

  // Register-file model. rf_mode: 0 = normal handshake, 1 = rdy stuck high, 2 = rdy stuck low.
  logic [1:0]    rf_mode = 2'd0;
  logic [DW-1:0] rf_mem [8];
  logic          probe_en  = 1'b0;
  logic [DW-1:0] probe_val = '0;

  assign u_if.gpr_rdy = (rf_mode == 2'd0) ? ~u_if.gpr_cs : (rf_mode == 2'd1);
  assign gpr_data = (rf_mode == 2'd0 && u_if.gpr_cs && u_if.gpr_read)
                    ? rf_mem[u_if.gpr_address[RS-1:0]] : {DW{1'bz}};
  // Probe driver: shows the bus is released when nobody else should drive it.
  assign gpr_data = probe_en ? probe_val : {DW{1'bz}};

  always @(posedge clk) begin
    if (rf_mode == 2'd0 && u_if.gpr_cs && !u_if.gpr_read)
      rf_mem[u_if.gpr_address[RS-1:0]] <= gpr_data;
  end

  logic [DW-1:0] exp_regs [8];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic probe_released(input string tag);
    probe_val = DW'($urandom);
    probe_en  = 1'b1;
    #1;
    check(tag, 32'(gpr_data), 32'(probe_val));
    probe_en  = 1'b0;
  endtask

  // Starts just after a negedge with the DUT idle and gpr_rdy high; ends at the idle negedge.
  task automatic do_wb(input int unsigned rd, input logic [DW-1:0] d);
    u_if.wb_valid = 1'b1;
    u_if.wb_rd    = RS'(rd);
    u_if.wb_data  = d;
    #1;
    check("wb_ready", 32'(u_if.wb_ready), 32'd1);
    check("wb_fetch_ready_low", 32'(u_if.fetch_ready), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      u_if.wb_valid = 1'b0;
      check("wb_fetch_blocked", 32'(u_if.fetch_ready), 32'd0);
      if (k < 3) begin
        check("wb_cs", 32'(u_if.gpr_cs), 32'd1);
        check("wb_read", 32'(u_if.gpr_read), 32'd0);
        check("wb_addr", 32'(u_if.gpr_address), rd);
        check("wb_data", 32'(gpr_data), 32'(d));
      end else begin
        check("wb_release_cs", 32'(u_if.gpr_cs), 32'd0);
        probe_released("wb_release_z");
      end
    end
    @(negedge clk);
    exp_regs[rd] = d;
    probe_released("wb_idle_z");
  endtask

  task automatic do_fetch(input int unsigned rs1, input int unsigned rs2);
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    ea = exp_regs[rs1];
    eb = exp_regs[rs2];
    u_if.fetch_valid = 1'b1;
    u_if.fetch_rs1   = RS'(rs1);
    u_if.fetch_rs2   = RS'(rs2);
    #1;
    check("fetch_ready", 32'(u_if.fetch_ready), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      u_if.fetch_valid = 1'b0;
      case (k)
        1: begin
          check("rd1_cs", 32'(u_if.gpr_cs), 32'd1);
          check("rd1_read", 32'(u_if.gpr_read), 32'd1);
          check("rd1_addr", 32'(u_if.gpr_address), rs1);
        end
        3: check("rd1_release_cs", 32'(u_if.gpr_cs), 32'd0);
        4: begin
          check("rd2_cs", 32'(u_if.gpr_cs), 32'd1);
          check("rd2_addr", 32'(u_if.gpr_address), rs2);
        end
        6: check("rd2_release_cs", 32'(u_if.gpr_cs), 32'd0);
        default: ;
      endcase
      check("op_valid_timing", 32'(u_if.op_valid), (k == 7) ? 32'd1 : 32'd0);
    end
    check("op_a", 32'(u_if.op_a), 32'(ea));
    check("op_b", 32'(u_if.op_b), 32'(eb));
    @(negedge clk);
    check("op_valid_pulse_end", 32'(u_if.op_valid), 32'd0);
    check("op_a_stable", 32'(u_if.op_a), 32'(ea));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.fetch_valid = 1'b0;
    u_if.fetch_rs1   = '0;
    u_if.fetch_rs2   = '0;
    u_if.wb_valid    = 1'b0;
    u_if.wb_rd       = '0;
    u_if.wb_data     = '0;
    for (int i = 0; i < 8; i++) exp_regs[i] = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cs", 32'(u_if.gpr_cs), 32'd0);
    check("rst_read", 32'(u_if.gpr_read), 32'd1);
    check("rst_addr", 32'(u_if.gpr_address), 32'd0);
    check("rst_op_valid", 32'(u_if.op_valid), 32'd0);
    check("rst_op_a", 32'(u_if.op_a), 32'd0);
    check("rst_op_b", 32'(u_if.op_b), 32'd0);
    check("rst_bus_err", 32'(u_if.bus_err), 32'd0);
    probe_released("rst_data_z");
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the register file through the bus
    for (int r = 0; r < 8; r++) do_wb(r, DW'($urandom));

    // Basic fetch
    do_wb(3, 16'h1234);
    do_wb(5, 16'hBEEF);
    do_fetch(3, 5);

    // Writeback lands in the register file
    do_wb(2, 16'hA5A5);
    check("rf_r2", 32'(rf_mem[2]), 32'h0000_A5A5);

    // Simultaneous writeback and fetch: writeback first, fetch sees new value
    u_if.fetch_valid = 1'b1;
    u_if.fetch_rs1   = 3'd4;
    u_if.fetch_rs2   = 3'd4;
    do_wb(4, 16'h0F0F);
    do_fetch(4, 4);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) do_wb($urandom_range(0, 7), DW'($urandom));
      else do_fetch($urandom_range(0, 7), $urandom_range(0, 7));
    end

    // gpr_rdy low in IDLE blocks acceptance
    rf_mode = 2'd2;
    u_if.fetch_valid = 1'b1;
    u_if.fetch_rs1   = 3'd6;
    u_if.fetch_rs2   = 3'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("busy_fetch_ready", 32'(u_if.fetch_ready), 32'd0);
      check("busy_cs", 32'(u_if.gpr_cs), 32'd0);
      @(negedge clk);
    end
    rf_mode = 2'd0;
    do_fetch(6, 7);

    // Timeout: register file never drops rdy
    rf_mode = 2'd1;
    u_if.fetch_valid = 1'b1;
    u_if.fetch_rs1   = 3'd1;
    u_if.fetch_rs2   = 3'd2;
    #1;
    check("to_fetch_ready", 32'(u_if.fetch_ready), 32'd1);
    @(negedge clk);
    u_if.fetch_valid = 1'b0;
    repeat (TO) @(negedge clk);
    check("to_err_not_yet", 32'(u_if.bus_err), 32'd0);
    check("to_cs_held", 32'(u_if.gpr_cs), 32'd1);
    @(negedge clk);
    check("to_bus_err", 32'(u_if.bus_err), 32'd1);
    check("to_cs_dropped", 32'(u_if.gpr_cs), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("to_no_op_valid", 32'(u_if.op_valid), 32'd0);
    end
    rf_mode = 2'd0;
    do_wb(1, 16'h5A3C);
    do_fetch(1, 2);
    check("to_err_sticky", 32'(u_if.bus_err), 32'd1);

    // Reset during RD2 transfer
    u_if.fetch_valid = 1'b1;
    u_if.fetch_rs1   = 3'd1;
    u_if.fetch_rs2   = 3'd6;
    #1;
    @(negedge clk);
    u_if.fetch_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rd2_addr", 32'(u_if.gpr_address), 32'd6);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_cs", 32'(u_if.gpr_cs), 32'd0);
    check("arst_read", 32'(u_if.gpr_read), 32'd1);
    check("arst_addr", 32'(u_if.gpr_address), 32'd0);
    check("arst_op_a", 32'(u_if.op_a), 32'd0);
    check("arst_op_b", 32'(u_if.op_b), 32'd0);
    check("arst_bus_err", 32'(u_if.bus_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("arst_no_op_valid", 32'(u_if.op_valid), 32'd0);
    end
    do_fetch(6, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gpr_access_ctrl.md
Name: gpr_access_ctrl

Overview:
- Bus master sitting directly upstream of the general-purpose register file.
- Turns execute-stage requests into transactions on the register file's cs/read/address/data/rdy bus:
  - an operand fetch: two sequential reads, rs1 then rs2;
  - a writeback: one write.
- Arbitrates between the two request types, sequences the register file's 3-cycle handshake, captures read data and flags bus timeouts.

Parameters:
- DATA_WIDTH, 16, width of register data and of the gpr_data bus
- ADDR_WIDTH, 16, width of gpr_address
- REG_SEL, 3, number of low address bits that select a register (8 registers)
- TIMEOUT, 15, maximum cycles to wait for any single gpr_rdy edge before aborting

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_valid  in  1  operand fetch request
- fetch_ready  out  1  fetch accepted this cycle (combinational)
- fetch_rs1  in  REG_SEL  first source register
- fetch_rs2  in  REG_SEL  second source register
- op_valid  out  1  one-cycle pulse: op_a/op_b hold the completed fetch
- op_a  out  DATA_WIDTH  value read from rs1
- op_b  out  DATA_WIDTH  value read from rs2
- wb_valid  in  1  writeback request
- wb_ready  out  1  writeback accepted this cycle (combinational)
- wb_rd  in  REG_SEL  destination register
- wb_data  in  DATA_WIDTH  writeback value
- gpr_cs  out  1  register-file chip select
- gpr_read  out  1  1 = read, 0 = write
- gpr_address  out  ADDR_WIDTH  register index, zero-extended
- gpr_data  inout  DATA_WIDTH  shared data bus
- gpr_rdy  in  1  register-file ready; 1 = idle
- bus_err  out  1  sticky timeout flag

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE; gpr_cs=0, gpr_read=1, gpr_address=0, gpr_data released (Z).
  - op_valid=0, op_a=0, op_b=0, bus_err=0; timeout counter=0.
  - Reset mid-transaction aborts the job immediately; no op_valid pulse.
- All bus outputs are registered. Latched job fields: kind (WB, RD1, RD2), rs2, write data.
- FSM states:
  - IDLE: accept a request only when gpr_rdy=1.
    - wb_valid has priority: wb_ready=1, latch wb_rd and wb_data, job=WB, go ISSUE.
    - Otherwise, if fetch_valid: fetch_ready=1, latch rs1 and rs2, job=RD1, go ISSUE.
    - Simultaneous wb_valid and fetch_valid: writeback first; fetch_ready stays 0 and the fetch is taken on a later IDLE cycle. A fetch of wb_rd therefore returns the new value.
  - ISSUE: gpr_cs=1, gpr_read=(job!=WB), gpr_address=selected register; for WB, gpr_data=write data.
    - Hold until gpr_rdy=0, then go XFER.
  - XFER: bus outputs held.
    - RD1 samples gpr_data into op_a at the end of the cycle; RD2 into op_b.
    - Then go RELEASE with gpr_cs=0.
  - RELEASE: gpr_cs=0, gpr_data=Z. Wait for gpr_rdy=1, then:
    - RD1 becomes RD2 (address=rs2), go ISSUE;
    - RD2 pulses op_valid for 1 cycle, go IDLE;
    - WB goes IDLE.
- gpr_data is driven only in ISSUE and XFER of a WB job, otherwise Z. gpr_cs is never held across a RELEASE cycle, so the register file cannot restart a transaction.
- Latency, from accept edge to op_valid pulse or IDLE:
  - Nominal read: 3 cycles (ISSUE, XFER, RELEASE).
  - Fetch: 6 cycles, then op_valid pulse.
  - Writeback: 3 cycles.
- Timeout:
  - Counter clears on each state entry and increments while ISSUE waits for gpr_rdy=0 or RELEASE waits for gpr_rdy=1.
  - At count==TIMEOUT: set bus_err (sticky until reset), drop gpr_cs, release gpr_data, abandon the job, go IDLE.
  - An abandoned fetch produces no op_valid; op_a/op_b keep whatever was already captured.
- op_a and op_b change only in XFER; they are stable between fetches.
- Only register bits [REG_SEL-1:0] are meaningful; upper gpr_address bits are 0.

Test Plan:
- Reset release; model writes R3=16'h1234 and R5=16'hBEEF; fetch rs1=3, rs2=5 -> op_valid pulses 6 cycles after accept with op_a=1234 and op_b=BEEF; gpr_cs low in both RELEASE cycles.
- wb rd=2, data=16'hA5A5 -> gpr_cs=1, gpr_read=0, gpr_address=2, gpr_data=A5A5 in ISSUE/XFER; gpr_data=Z otherwise; model R2=A5A5.
- wb rd=4, data=16'h0F0F in the same cycle as fetch rs1=4, rs2=4 -> wb_ready=1, fetch_ready=0; fetch accepted later; op_a=op_b=0F0F.
- Model holds gpr_rdy=1 forever after cs -> bus_err=1 after 15 wait cycles; gpr_cs=0; no op_valid; next request still serviced and bus_err stays 1.
- rst_n asserted during XFER of RD2 -> outputs return to reset values asynchronously; no op_valid; a fresh fetch afterwards completes normally.
- fetch_valid with gpr_rdy=0 in IDLE -> fetch_ready stays 0 until gpr_rdy=1.
